// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = inp_1 - inp_2, LSB first) with start/busy/done handshake.
// Optional build macro SERIAL_SUB_SATURATE_EN clamps a borrowing result to zero.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp_1,
  input  logic [WIDTH-1:0] inp_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [IdxW-1:0]  idx_q;
  logic             bin_q, borrow_q, done_q;
  logic             d_bit, bout;

  // Single full-subtractor cell, reused every RUN cycle.
  assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StRun);
    done   = done_q;
    diff   = diff_q;
    borrow = borrow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StFin);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= inp_1;
            b_q   <= inp_2;
            bin_q <= 1'b0;
            idx_q <= '0;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          bin_q <= bout;
          idx_q <= idx_q + IdxW'(1);
        end
        StFin: begin
`ifdef SERIAL_SUB_SATURATE_EN
          diff_q <= bin_q ? '0 : res_q;
`else
          diff_q <= res_q;
`endif
          borrow_q <= bin_q;
        end
        default: ;
      endcase
    end
  end

endmodule
